// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared fsm states, grant codes and ctrl handshake constants
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] GNT_M0 = 2'd0;
  localparam logic [1:0] GNT_M1 = 2'd1;
  localparam logic [1:0] GNT_M2 = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;
  localparam logic RIB_REQ = 1'b1;
  localparam logic [2:0] HOLD_ID = 3'b011;
endpackage

// File: rtl/mem_bus_arbiter_prio_sel.sv
// arb_prio_sel: m2-first winner pick with alternating m0/m1 tie-break
module arb_prio_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = req2 ? GNT_M2 : (req0 && req1) ? (last ? GNT_M0 : GNT_M1) : req0 ? GNT_M0 : req1 ? GNT_M1 : GNT_NONE;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises three masters onto one timed req/ack memory bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_ack_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_ack_o,
  input  logic          m2_req_i,
  input  logic          m2_we_i,
  input  logic [AW-1:0] m2_addr_i,
  input  logic [DW-1:0] m2_wdata_i,
  output logic [DW-1:0] m2_rdata_o,
  output logic          m2_ack_o,
  output logic          s_req_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  input  logic [DW-1:0] s_rdata_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant_o,
  output logic          err_o,
  output logic          hold_req_o
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic last, fin, timed_out, sel_we;
  logic [CW-1:0] cnt;
  logic [1:0] win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, rd;
  arb_prio_sel u_sel (
    .req0 (m0_req_i),
    .req1 (m1_req_i),
    .req2 (m2_req_i),
    .last (last),
    .grant(win)
  );
  always_comb begin
    timed_out = state == BUSY && !s_ack_i && cnt == CW'(TIMEOUT - 1);
    fin = (state == BUSY && s_ack_i) || timed_out;
    rd = (state == BUSY && s_ack_i && !s_we_o) ? s_rdata_i : '0;
    sel_we = win == GNT_M2 ? m2_we_i : win == GNT_M1 ? m1_we_i : m0_we_i;
    sel_addr = win == GNT_M2 ? m2_addr_i : win == GNT_M1 ? m1_addr_i : m0_addr_i;
    sel_wdata = win == GNT_M2 ? m2_wdata_i : win == GNT_M1 ? m1_wdata_i : m0_wdata_i;
    state_nx = state == IDLE ? (win == GNT_NONE ? IDLE : BUSY) : state == BUSY ? (fin ? DONE : BUSY) : IDLE;
    hold_req_o = m0_req_i && !(state == DONE && grant_o == GNT_M0);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_o <= GNT_NONE;
      last <= 1'b1;
      cnt <= '0;
      s_req_o <= 1'b0;
      s_we_o <= 1'b0;
      s_addr_o <= '0;
      s_wdata_o <= '0;
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m2_ack_o <= 1'b0;
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
      m2_rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      cnt <= state == BUSY ? cnt + CW'(1) : '0;
      err_o <= timed_out;
      m0_ack_o <= fin && grant_o == GNT_M0;
      m1_ack_o <= fin && grant_o == GNT_M1;
      m2_ack_o <= fin && grant_o == GNT_M2;
      m0_rdata_o <= (fin && grant_o == GNT_M0) ? rd : '0;
      m1_rdata_o <= (fin && grant_o == GNT_M1) ? rd : '0;
      m2_rdata_o <= (fin && grant_o == GNT_M2) ? rd : '0;
      if (state == IDLE && win != GNT_NONE) begin
        grant_o <= win;
        s_req_o <= RIB_REQ;
        s_we_o <= sel_we;
        s_addr_o <= sel_addr;
        s_wdata_o <= sel_wdata;
      end
      if (fin) s_req_o <= 1'b0;
      if (state == DONE) begin
        grant_o <= GNT_NONE;
        if (grant_o != GNT_M2) last <= grant_o == GNT_M1;
      end
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the single data-memory bus between three masters:
  - **m0**: MEM stage, the load/store path feeding mem_wb.
  - **m1**: instruction fetch.
  - **m2**: debug port.
- Serialises requests into one transaction at a time with a req/ack handshake toward the slave.
- Bounds every transaction with a timeout.
- Raises a hold request to ctrl while the MEM stage waits, so ctrl can stall the pipeline at Hold_Id (3'b011).

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max BUSY cycles before abort (≥2)

Ports (N = 0..2, one family per line):
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mN_req_i  in  1  master N request; held high until mN_ack_o
- mN_we_i  in  1  master N write enable
- mN_addr_i  in  AW  master N address
- mN_wdata_i  in  DW  master N write data
- mN_rdata_o  out  DW  read data; valid only while mN_ack_o=1
- mN_ack_o  out  1  one-cycle completion pulse
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  AW  slave address
- s_wdata_o  out  DW  slave write data
- s_rdata_i  in  DW  slave read data
- s_ack_i  in  1  slave completion (single cycle)
- grant_o  out  2  current owner: 0=m0, 1=m1, 2=m2, 3=none
- err_o  out  1  one-cycle pulse on timeout
- hold_req_o  out  1  MEM-stage stall request to ctrl

## Operation
FSM states:
- **IDLE**:
  - Picks a winner among asserted requests.
  - Priority: m2 > {m0, m1}.
  - m0 vs m1 alternates via a `last` bit: when both request, the one not granted last wins.
  - Latches we/addr/wdata of the winner into slave registers, sets grant, goes to BUSY.
  - No request: stays in IDLE with grant_o=3.
- **BUSY**:
  - s_req_o=1; s_we/addr/wdata held stable.
  - Cycle counter counts from 0.
  - On s_ack_i: latch s_rdata_i (0 for writes), go to DONE.
  - If counter reaches TIMEOUT-1 with no ack: rdata=0, err flag set, go to DONE.
  - s_ack_i and timeout in the same cycle: ack wins, no error.
- **DONE**:
  - s_req_o=0; ack pulsed to the granted master with the registered rdata; err_o pulses if timed out.
  - Update `last` (m0/m1 only), go to IDLE.
  - The granted master's request is ignored this cycle, so it may drop req here.

Other rules:
- s_ack_i outside BUSY is ignored.
- hold_req_o = m0_req_i & ~(DONE & grant==0). This is combinational.
- Non-granted masters see ack=0 and rdata=0.

## Timing
- All outputs except hold_req_o are registered.
- Reset values:
  - state IDLE, grant_o=3, `last`=1 (m0 wins first tie).
  - s_req_o, s_we_o, all mN_ack_o, err_o = 0.
  - s_addr_o, s_wdata_o, all mN_rdata_o, counter = 0.
- Latency, req first seen at cycle t in IDLE:
  - s_req_o high at t+1.
  - Ack at t+k (k≥1) gives mN_ack_o at t+k+1.
  - Minimum request-to-ack is 2 cycles; back-to-back throughput is one transaction per 3 cycles.
- Timeout: s_req_o high for exactly TIMEOUT cycles, then ack+err pulse in the next cycle.
- Reset mid-BUSY:
  - Next cycle returns to reset values.
  - No ack or err is emitted for the aborted transaction.
  - s_req_o drops immediately.
- A request dropped before ack still completes on the bus; the ack goes to the granted master regardless.

## Structure
- Shared defines file:
  - FSM state encodings IDLE/BUSY/DONE.
  - Grant codes GNT_M0/M1/M2/NONE.
  - Reuse the existing RIB_REQ / Hold_Id constants.
- Sub-module **arb_prio_sel**: combinational winner pick from three requests plus `last`, outputting a 2-bit grant code.
- Counter, FSM and data registers live in the top module.

## Test plan
- **Single m0 read:**
  - Stimulus: m0 addr 0x100; slave acks at the first BUSY cycle with 0xDEADBEEF.
  - Response: s_req_o for 1 cycle; m0_ack_o at cycle 3 with rdata 0xDEADBEEF; hold_req_o high cycles 1–2, low at 3.
- **m0 and m1 contend continuously:**
  - Stimulus: m0 and m1 both request and re-request; slave acks immediately.
  - Response: grants alternate m0, m1, m0, m1; m2 asserted mid-stream wins the next IDLE.
- **Timeout:**
  - Stimulus: TIMEOUT=4; slave never acks.
  - Response: s_req_o high 4 cycles; then ack+err_o pulse with rdata 0; FSM returns to IDLE.
- **Ack coincident with timeout:**
  - Stimulus: ack on the 4th BUSY cycle.
  - Response: err_o=0; data 0x5A5A5A5A delivered.
- **Reset in BUSY:**
  - Stimulus: rst asserted during BUSY.
  - Response: next cycle all outputs at reset values; no ack pulse; a late s_ack_i is ignored.
- **m1 write:**
  - Stimulus: m1 writes 0x12345678 to 0x200.
  - Response: s_we_o=1, s_addr_o=0x200, s_wdata_o=0x12345678 stable through BUSY; m1_ack_o pulses once with rdata 0.
